// File: rtl/icache_1way.sv
// Direct-mapped, read-only instruction cache between the picorv32 fetch port and instruction memory.
// A miss refills the whole line in ascending word order, with one idle cycle after every word.
//
// state  | meaning
// IDLE   | waiting for a fetch; tag lookup and hit data come straight from the arrays
// REFILL | requesting line word cnt_q from memory, held until mem_req_ready
// GAP    | one dead cycle after each refill word; the last GAP commits tag and valid
// RESP   | proc_ready pulse carrying proc_rdata captured earlier
module icache_1way #(
  parameter int NUM_LINES  = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        proc_valid,
  output logic        proc_ready,
  input  logic [31:0] proc_addr,
  output logic [31:0] proc_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_rdata
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int CW = (OB > 0) ? OB : 1;
  localparam int TW = 30 - OB - IB;
  localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, GAP, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] lat_tag_q, lat_tag_d;
  logic [IB-1:0] lat_idx_q, lat_idx_d;
  logic [CW-1:0] lat_off_q, lat_off_d;
  logic [31:0]   mem_req_addr_q, mem_req_addr_d;
  logic [31:0]   proc_rdata_q, proc_rdata_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

  logic [TW-1:0] req_tag;
  logic [IB-1:0] req_idx;
  logic [CW-1:0] req_off;
  logic          hit;
  logic [31:0]   hit_word;
  logic          data_we;
  logic          line_done;
  logic          unused_addr_lsbs;

  assign req_tag = proc_addr[31:OB+IB+2];
  assign req_idx = proc_addr[OB+IB+1:OB+2];
  assign unused_addr_lsbs = ^proc_addr[1:0];

  generate
    if (OB > 0) begin : g_off
      assign req_off = proc_addr[OB+1:2];
    end else begin : g_no_off
      assign req_off = '0;
    end
  endgenerate

  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word = data_q[req_idx][req_off];

  function automatic logic [31:0] line_addr(input logic [TW-1:0] t,
                                            input logic [IB-1:0] i,
                                            input logic [CW-1:0] w);
    logic [31:0] a;
    a = {t, i, {(OB+2){1'b0}}};
    a = a | (32'(w) << 2);
    return a;
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lat_tag_d      = lat_tag_q;
    lat_idx_d      = lat_idx_q;
    lat_off_d      = lat_off_q;
    mem_req_addr_d = mem_req_addr_q;
    proc_rdata_d   = proc_rdata_q;
    data_we        = 1'b0;
    line_done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (proc_valid) begin
          if (hit) begin
            proc_rdata_d = hit_word;
            state_d      = RESP;
          end else begin
            lat_tag_d      = req_tag;
            lat_idx_d      = req_idx;
            lat_off_d      = req_off;
            cnt_d          = '0;
            mem_req_addr_d = line_addr(req_tag, req_idx, '0);
            state_d        = REFILL;
          end
        end
      end
      REFILL: begin
        if (mem_req_ready) begin
          data_we = 1'b1;
          if (cnt_q == lat_off_q) proc_rdata_d = mem_req_rdata;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == LAST_WORD) begin
          line_done = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d          = cnt_q + 1'b1;
          mem_req_addr_d = line_addr(lat_tag_q, lat_idx_q, cnt_q + 1'b1);
          state_d        = REFILL;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lat_tag_q      <= '0;
      lat_idx_q      <= '0;
      lat_off_q      <= '0;
      mem_req_addr_q <= '0;
      proc_rdata_q   <= '0;
      valid_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_tag_q      <= lat_tag_d;
      lat_idx_q      <= lat_idx_d;
      lat_off_q      <= lat_off_d;
      mem_req_addr_q <= mem_req_addr_d;
      proc_rdata_q   <= proc_rdata_d;
      if (line_done) valid_q[lat_idx_q] <= 1'b1;
    end
  end

  // Arrays carry no reset; an aborted refill only leaves data behind an invalid line.
  always_ff @(posedge clk) begin
    if (data_we && !resetn) data_q[lat_idx_q][cnt_q] <= mem_req_rdata;
    if (line_done && !resetn) tag_q[lat_idx_q] <= lat_tag_q;
  end

  assign proc_ready    = (state_q == RESP);
  assign mem_req_valid = (state_q == REFILL);
  assign mem_req_addr  = mem_req_addr_q;
  assign proc_rdata    = proc_rdata_q;

endmodule

// File: tb/tb_icache_1way.sv
// Bench for icache_1way: line-granular cache model, randomized memory timing and fetch mix,
// plus directed scenarios pinned with hand-computed literals.
module tb_icache_1way;
  localparam int NL = 256;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        proc_valid = 1'b0;
  logic [31:0] proc_addr = 32'h0;
  logic        proc_ready;
  logic [31:0] proc_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  bit          hash_mode = 0;
  bit          stall_mode = 0;
  bit          rand_delay = 0;
  bit          spurious = 0;

  bit          m_valid [NL];
  logic [31:0] m_line  [NL];
  logic [31:0] exp_mem_q[$];
  logic [31:0] mem_log[$];

  bit          fetch_active = 0;
  bit          resp_seen = 0;
  int          n_cnt = 0;
  int          lat_sum = 0;
  logic [31:0] exp_data = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = 0;

  bit          in_req = 0;
  bit          ack_prev = 0;
  int          wait_cnt = 0;
  int          cur_delay = 0;
  logic [31:0] req_addr = 0;

  icache_1way #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .proc_valid   (proc_valid),
    .proc_ready   (proc_ready),
    .proc_addr    (proc_addr),
    .proc_rdata   (proc_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_rdata(mem_req_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (!hash_mode) return a;
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_log(input string name, input logic [31:0] base);
    check({name, "_count"}, 32'(mem_log.size()), 32'(LW));
    if (mem_log.size() == LW)
      for (int k = 0; k < LW; k++) check({name, "_addr"}, mem_log[k], base + 32'(4 * k));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 0;
    exp_mem_q.delete();
  endtask

  // Memory side: responds after a chosen delay, checks request order, stability and the gap.
  always @(negedge clk) begin
    if (ack_prev) check("gap_after_word", {31'b0, mem_req_valid}, 32'h0);
    ack_prev = 0;
    if (mem_req_valid) begin
      if (!in_req) begin
        in_req = 1;
        wait_cnt = 0;
        req_addr = mem_req_addr;
        cur_delay = stall_mode ? 5 : (rand_delay ? int'($urandom_range(0, 3)) : 0);
        mem_log.push_back(mem_req_addr);
        total++;
        if (exp_mem_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_mem_req: got %h required none", mem_req_addr);
        end else begin
          check("refill_addr", mem_req_addr, exp_mem_q.pop_front());
        end
      end else begin
        check("stall_addr_stable", mem_req_addr, req_addr);
      end
      if (wait_cnt == cur_delay) begin
        mem_req_ready = 1'b1;
        mem_req_rdata = mem_data(mem_req_addr);
        lat_sum += cur_delay + 2;
        in_req = 0;
        ack_prev = 1;
      end else begin
        wait_cnt++;
        mem_req_ready = 1'b0;
        mem_req_rdata = $urandom;
      end
    end else begin
      in_req = 0;
      mem_req_ready = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
      mem_req_rdata = $urandom;
    end
  end

  // Processor side compare: latency, returned word, and no stray proc_ready.
  always @(negedge clk) begin
    if (fetch_active) n_cnt++;
    if (!fetch_active || resp_seen) begin
      check("no_stray_ready", {31'b0, proc_ready}, 32'h0);
    end else if (proc_ready) begin
      check("latency", 32'(n_cnt), 32'(lat_sum + 2));
      check("rdata", proc_rdata, exp_data);
      last_lat = n_cnt;
      last_rdata = proc_rdata;
      resp_seen = 1;
    end
  end

  task automatic fetch_start(input logic [31:0] a);
    logic [31:0] line;
    int idx;
    line = a >> 4;
    idx = int'(line % NL);
    exp_data = mem_data(a & ~32'h3);
    if (!(m_valid[idx] && m_line[idx] == line)) begin
      for (int k = 0; k < LW; k++) exp_mem_q.push_back((line << 4) + 32'(4 * k));
      m_valid[idx] = 1;
      m_line[idx] = line;
    end
    lat_sum = 0;
    n_cnt = 0;
    resp_seen = 0;
    fetch_active = 1;
    proc_addr = a;
    proc_valid = 1'b1;
  endtask

  task automatic fetch_wait();
    int t;
    t = 0;
    while (!resp_seen && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (!resp_seen) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: got no proc_ready required one for addr %h", proc_addr);
    end
    fetch_active = 0;
    proc_valid = 1'b0;
    proc_addr = $urandom;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    mem_log.delete();
    fetch_start(a);
    fetch_wait();
  endtask

  task automatic apply_reset(input int cycles);
    resetn = 1'b1;
    proc_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] tags [4];
    int t;
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2; tags[3] = 32'hABCDE;
    model_reset();

    apply_reset(3);
    check("reset_proc_ready", {31'b0, proc_ready}, 32'h0);
    check("reset_mem_valid", {31'b0, mem_req_valid}, 32'h0);
    check("reset_mem_addr", mem_req_addr, 32'h0);
    check("reset_proc_rdata", proc_rdata, 32'h0);

    do_fetch(32'h0);
    check("cold_lat", 32'(last_lat), 32'd10);
    check("cold_rdata", last_rdata, 32'h0);
    check_log("cold_log", 32'h0);

    do_fetch(32'h8);
    check("hit_lat", 32'(last_lat), 32'd2);
    check("hit_rdata", last_rdata, 32'h8);
    check("hit_no_mem", 32'(mem_log.size()), 32'h0);

    do_fetch(32'h24);
    check("mid_rdata", last_rdata, 32'h24);
    check_log("mid_log", 32'h20);
    do_fetch(32'h20);
    check("mid_hit_lat", 32'(last_lat), 32'd2);
    check("mid_hit_rdata", last_rdata, 32'h20);

    do_fetch(32'h1004);
    check("conflict_rdata", last_rdata, 32'h1004);
    check_log("conflict_log", 32'h1000);
    do_fetch(32'h4);
    check("evicted_lat", 32'(last_lat), 32'd10);
    check("evicted_rdata", last_rdata, 32'h4);
    check_log("evicted_log", 32'h0);

    stall_mode = 1;
    do_fetch(32'h2008);
    check("stall_lat", 32'(last_lat), 32'd30);
    check("stall_rdata", last_rdata, 32'h2008);
    check_log("stall_log", 32'h2000);
    stall_mode = 0;

    mem_log.delete();
    fetch_start(32'h3010);
    t = 0;
    while (!(mem_req_valid && mem_req_addr == 32'h3018) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("reach_word2", 32'(t < 200), 32'h1);
    resetn = 1'b1;
    proc_valid = 1'b0;
    fetch_active = 0;
    @(posedge clk); #1;
    check("abort_mem_valid", {31'b0, mem_req_valid}, 32'h0);
    check("abort_proc_ready", {31'b0, proc_ready}, 32'h0);
    resetn = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_fetch(32'h3010);
    check("refetch_lat", 32'(last_lat), 32'd10);
    check("refetch_rdata", last_rdata, 32'h3010);
    check_log("refetch_log", 32'h3010);

    hash_mode = 1;
    apply_reset(2);
    rand_delay = 1;
    spurious = 1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = (tags[$urandom_range(0, 3)] << 12) | (32'($urandom_range(0, 7)) << 4)
          | 32'($urandom_range(0, 15));
      do_fetch(a);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) begin
      @(posedge clk); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_1way.md
Name: icache_1way

Overview:
- Read-only, direct-mapped (one-way) instruction cache.
- Sits between the picorv32 instruction-fetch port and the instruction memory.
- On a hit it returns the word after one cycle.
- On a miss it refills the whole line from memory, one word at a time, then returns the requested word.

Parameters:
- NUM_LINES, 256, number of cache lines; power of two, ≥ 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥ 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  synchronous reset, active-high (1 = reset), sampled on the rising edge of clk.
- proc_valid  in  1  fetch request; held high with a stable proc_addr until proc_ready.
- proc_ready  out  1  one-cycle pulse; proc_rdata is valid in that cycle.
- proc_addr  in  32  byte address; bits [1:0] are ignored.
- proc_rdata  out  32  fetched instruction word.
- mem_req_valid  out  1  refill word request to memory.
- mem_req_ready  in  1  memory response strobe; mem_req_rdata is valid in that cycle.
- mem_req_addr  out  32  word-aligned refill address.
- mem_req_rdata  in  32  refill data.

Behaviour:
- Address split, with OB = log2(LINE_WORDS) and IB = log2(NUM_LINES):
  - word offset = addr[OB+1:2]
  - index = addr[OB+IB+1:OB+2]
  - tag = remaining upper bits.
  - Defaults: offset [3:2], index [11:4], tag [31:12].
- Storage:
  - per line: valid bit, tag, LINE_WORDS data words.
  - Data and tag arrays need no reset.
- Reset (resetn = 1 at an edge):
  - clear all valid bits; state = IDLE.
  - proc_ready = 0, mem_req_valid = 0, word counter = 0.
  - mem_req_addr and proc_rdata = 0.
  - Reset during a refill aborts it; the line stays invalid and mem_req_valid is 0 from the next cycle.
- State IDLE:
  - Act when proc_valid = 1 at an edge.
  - Hit (line valid and tag equal): go to RESP; proc_rdata = the stored word.
  - Miss: latch the address, go to REFILL with word counter = 0.
- State REFILL:
  - mem_req_valid = 1.
  - mem_req_addr = {latched tag, latched index, counter, 2'b00}.
  - On mem_req_ready: write mem_req_rdata into that line word; if it is the requested offset, also capture it into proc_rdata.
  - Then deassert mem_req_valid for exactly one cycle (GAP).
  - If more words remain: counter +1, back to REFILL.
  - After the last word: write the tag, set the valid bit, go to RESP.
- Refill order: words 0..LINE_WORDS-1, always in ascending order.
- State RESP:
  - proc_ready = 1 for exactly one cycle, with the proc_rdata captured earlier.
  - Next state IDLE.
  - proc_valid in this cycle is not treated as a new request.
- Latency:
  - Hit: proc_ready two edges after proc_valid is first sampled.
  - Miss: sum of memory response times plus one GAP per word plus RESP.
- Memory stalls: mem_req_valid and mem_req_addr stay stable for any number of cycles until mem_req_ready.
- mem_req_ready outside REFILL is ignored.
- proc_ready never rises without a pending proc_valid.
- Conflict miss: the new line overwrites the old line at the same index (no write-back; read-only).
- Back-to-back requests: a new request may be sampled in the IDLE cycle right after RESP.

Test Plan:
- Cold miss: reset; memory holds word at address N = N; fetch 0x0.
  - Expect mem requests 0x0, 0x4, 0x8, 0xC in order, each with a one-cycle gap.
  - Expect proc_ready pulse with rdata = 0x00000000.
- Hit after refill: fetch 0x8.
  - Expect proc_ready two edges after proc_valid, rdata = 0x00000008, mem_req_valid stays 0.
- Mid-line miss: fetch 0x24.
  - Expect refill 0x20..0x2C, rdata = 0x00000024.
  - A following fetch of 0x20 hits.
- Conflict eviction: fetch 0x1004 (same index as 0x4).
  - Expect refill 0x1000..0x100C, rdata = 0x00001004.
  - A following fetch of 0x4 misses and refills again.
- Memory stall: mem_req_ready delayed 5 cycles per word.
  - Expect mem_req_addr and mem_req_valid stable throughout, correct data, single proc_ready pulse.
- Reset mid-refill: assert resetn during word 2 of a refill.
  - Expect mem_req_valid = 0 the next cycle and no proc_ready.
  - Expect a re-fetch of the same address to miss and refill from word 0.
